// File: rtl/ca_stepper.sv
// ca_stepper
//   Sequencer for an 8-cell elementary cellular automaton that feeds a
//   downstream cycle_checker. A run loads a seed and a Wolfram rule, clears
//   the checker, then for every generation pulses the checker's compare
//   clock, samples its verdict, commits the generation to its history and
//   advances. The run ends on a reported repeat or when MAX_STEPS
//   generations have been advanced.
//
//   Optional feature macro: CA_WRAP_EN
//     defined   -> toroidal ring (cell 0 and cell 7 are neighbours)
//     undefined -> cells beyond either end read as 0
//
// Parameters
//   MAX_STEPS    generation budget, 1..255
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-low
//   start        level request, honoured only in IDLE and DONE
//   seed[0:7]    initial generation (index 0 = leftmost cell)
//   rule[7:0]    Wolfram rule number
//   cycle_found  checker verdict, sampled in WAIT
//   status[0:7]  current generation, to the checker
//   chk_clr      one-cycle pulse, to the checker's reset
//   check        one-cycle pulse, to the checker's compare clock
//   commit       one-cycle pulse, to the checker's history clock
//   busy         run in progress
//   done         run finished
//   cycle        run ended on a detected repeat
//   timeout      run ended on budget exhaustion
//   step_cnt     generations advanced in the current run
`timescale 1ns/1ps

module ca_stepper #(
   parameter int unsigned MAX_STEPS = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [0:7] seed,
   input  logic [7:0] rule,
   input  logic       cycle_found,
   output logic [0:7] status,
   output logic       chk_clr,
   output logic       check,
   output logic       commit,
   output logic       busy,
   output logic       done,
   output logic       cycle,
   output logic       timeout,
   output logic [7:0] step_cnt
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      CHECK  = 3'd2,
      WAIT   = 3'd3,
      COMMIT = 3'd4,
      STEP   = 3'd5,
      DONE   = 3'd6
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] rule_q;
   logic [7:0] step_inc;
   logic       last_step;
   logic [0:9] padded;
   logic [0:7] next_gen;

   // Generation with one guard cell on each side, so cell i sees its
   // {L,C,R} neighbourhood as padded[i +: 3].
`ifdef CA_WRAP_EN
   assign padded = {status[7], status, status[0]};
`else
   assign padded = {1'b0, status, 1'b0};
`endif

   always_comb begin
      next_gen = '0;
      for (int i = 0; i < 8; i++) begin
         next_gen[i] = rule_q[{padded[i], padded[i+1], padded[i+2]}];
      end
   end

   assign step_inc  = step_cnt + 8'd1;
   assign last_step = (step_inc == 8'(MAX_STEPS));

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      // NOTE: default assigned first so no path through the case leaves
      // state_nxt unassigned, which would infer a latch.
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = CLEAR;
         CLEAR:      state_nxt = CHECK;
         CHECK:      state_nxt = WAIT;
         WAIT:       state_nxt = cycle_found ? DONE : COMMIT;
         COMMIT:     state_nxt = STEP;
         STEP:       state_nxt = last_step ? DONE : CHECK;
         default:    state_nxt = IDLE;
      endcase
   end

   // Pulse and status outputs are flops loaded from the next state, so they
   // are glitch-free (check and commit clock the downstream checker) and
   // line up exactly with the state they describe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chk_clr <= 1'b0;
         check   <= 1'b0;
         commit  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         chk_clr <= (state_nxt == CLEAR);
         check   <= (state_nxt == CHECK);
         commit  <= (state_nxt == COMMIT);
         busy    <= (state_nxt != IDLE) && (state_nxt != DONE);
         done    <= (state_nxt == DONE);
      end
   end

   // Run datapath: generation, rule, step counter and end-of-run flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         status   <= '0;
         rule_q   <= '0;
         step_cnt <= '0;
         cycle    <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  status   <= seed;
                  rule_q   <= rule;
                  step_cnt <= '0;
                  cycle    <= 1'b0;
                  timeout  <= 1'b0;
               end
            end
            WAIT: begin
               if (cycle_found) cycle <= 1'b1;
            end
            STEP: begin
               status   <= next_gen;
               step_cnt <= step_inc;
               if (last_step) timeout <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ca_stepper.sv
// Testbench for ca_stepper: a behavioural cycle_checker (history queue)
// answers the stepper's compare pulses; table vectors, hand sequences for
// latency/busy/reset corners, and randomized rules/seeds scored against an
// arithmetic reference of the automaton.
`timescale 1ns/1ps

module tb_ca_stepper;

   logic       clk = 1'b0;
   logic       reset;

   // Default-budget instance with the checker model attached.
   logic       start_a, cycle_found_a = 1'b0;
   logic [0:7] seed_a;
   logic [7:0] rule_a;
   logic [0:7] status_a;
   logic       chk_clr_a, check_a, commit_a, busy_a, done_a, cycle_a, timeout_a;
   logic [7:0] step_cnt_a;

   // Short-budget instance whose verdict is tied low.
   logic       start_b, cycle_found_b;
   logic [0:7] seed_b;
   logic [7:0] rule_b;
   logic [0:7] status_b;
   logic       chk_clr_b, check_b, commit_b, busy_b, done_b, cycle_b, timeout_b;
   logic [7:0] step_cnt_b;

   int n_cmp = 0;
   int n_fail = 0;
   int n_clr = 0;
   int n_chk = 0;
   int n_com = 0;

   logic [7:0] hist[$];
   bit         found;

   always #5 clk = ~clk;

   assign cycle_found_b = 1'b0;

   ca_stepper u_dut (
      .clk(clk), .reset(reset), .start(start_a), .seed(seed_a), .rule(rule_a),
      .cycle_found(cycle_found_a), .status(status_a), .chk_clr(chk_clr_a),
      .check(check_a), .commit(commit_a), .busy(busy_a), .done(done_a),
      .cycle(cycle_a), .timeout(timeout_a), .step_cnt(step_cnt_a)
   );

   ca_stepper #(.MAX_STEPS(4)) u_dut4 (
      .clk(clk), .reset(reset), .start(start_b), .seed(seed_b), .rule(rule_b),
      .cycle_found(cycle_found_b), .status(status_b), .chk_clr(chk_clr_b),
      .check(check_b), .commit(commit_b), .busy(busy_b), .done(done_b),
      .cycle(cycle_b), .timeout(timeout_b), .step_cnt(step_cnt_b)
   );

   // Behavioural cycle_checker: clear on chk_clr, answer "seen before?" on
   // check (valid through the following cycle), append on commit.
   always @(negedge clk) begin
      if (!reset) begin
         hist.delete();
         cycle_found_a = 1'b0;
      end else begin
         if (chk_clr_a) begin
            hist.delete();
            n_clr++;
         end
         if (check_a) begin
            found = 1'b0;
            foreach (hist[i]) if (hist[i] == status_a) found = 1'b1;
            cycle_found_a = found;
            n_chk++;
         end
         if (commit_a) begin
            hist.push_back(status_a);
            n_com++;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Next generation as whole-word arithmetic: the left neighbours of all
   // cells form the word shifted one place toward the LSB, the right
   // neighbours the word shifted toward the MSB.
   function automatic logic [7:0] ref_next(input logic [7:0] g, input logic [7:0] r);
      int lv, rv, res;
      lv = int'(g) >> 1;
      rv = (int'(g) << 1) & 8'hFF;
`ifdef CA_WRAP_EN
      lv = lv | ((int'(g) & 1) << 7);
      rv = rv | ((int'(g) >> 7) & 1);
`endif
      res = 0;
      for (int b = 0; b < 8; b++) begin
         int idx;
         idx = 4 * ((lv >> b) & 1) + 2 * ((int'(g) >> b) & 1) + ((rv >> b) & 1);
         res = res | (((int'(r) >> idx) & 1) << b);
      end
      return 8'(res);
   endfunction

   task automatic ref_run(input logic [7:0] r, input logic [7:0] s, input int max_steps,
                          output logic cyc, output logic tmo, output int steps,
                          output logic [7:0] fin);
      bit seen [256];
      logic [7:0] g;
      foreach (seen[i]) seen[i] = 1'b0;
      g = s; steps = 0; cyc = 1'b0; tmo = 1'b0;
      forever begin
         if (seen[g]) begin cyc = 1'b1; break; end
         seen[g] = 1'b1;
         g = ref_next(g, r);
         steps++;
         if (steps == max_steps) begin tmo = 1'b1; break; end
      end
      fin = g;
   endtask

   task automatic wait_done_a(input string name);
      int n = 0;
      while (!done_a && n < 1200) begin @(negedge clk); n++; end
      check({name, "_done_seen"}, done_a, 1);
   endtask

   task automatic run_a(input logic [7:0] r, input logic [7:0] s, input string name);
      @(negedge clk);
      rule_a = r; seed_a = s; start_a = 1'b1;
      n_clr = 0; n_chk = 0; n_com = 0;
      @(negedge clk);
      start_a = 1'b0;
      wait_done_a(name);
   endtask

   typedef struct {
      logic [7:0] rule;
      logic [7:0] seed;
      logic       cyc;
      logic       tmo;
      int         steps;
      logic [7:0] fin;
      int         n_chk;
      int         n_com;
   } vec_t;

   vec_t vecs [5];

   initial begin
      logic       e_cyc, e_tmo;
      int         e_steps;
      logic [7:0] e_fin;
      logic [7:0] r, s;
      int         n;

      vecs[0] = '{8'h00, 8'hFF, 1'b1, 1'b0, 2, 8'h00, 3, 2};
      vecs[1] = '{8'hCC, 8'hA5, 1'b1, 1'b0, 1, 8'hA5, 2, 1};
`ifdef CA_WRAP_EN
      vecs[2] = '{8'hAA, 8'h01, 1'b1, 1'b0, 8, 8'h01, 9, 8};
      vecs[4] = '{8'hF0, 8'h80, 1'b1, 1'b0, 8, 8'h80, 9, 8};
`else
      vecs[2] = '{8'hAA, 8'h01, 1'b1, 1'b0, 9, 8'h00, 10, 9};
      vecs[4] = '{8'hF0, 8'h80, 1'b1, 1'b0, 9, 8'h00, 10, 9};
`endif
      vecs[3] = '{8'h00, 8'h00, 1'b1, 1'b0, 1, 8'h00, 2, 1};

      reset = 1'b0;
      start_a = 1'b0; seed_a = '0; rule_a = '0;
      start_b = 1'b0; seed_b = '0; rule_b = '0;
      repeat (2) @(negedge clk);
      check("rst_status", status_a, 0);
      check("rst_step_cnt", step_cnt_a, 0);
      check("rst_flags", {chk_clr_a, check_a, commit_a, busy_a, done_a, cycle_a, timeout_a}, 0);
      @(negedge clk);
      reset = 1'b1;

      // Start latency and status stability through one generation.
      @(negedge clk);
      rule_a = 8'hCC; seed_a = 8'hA5; start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      check("lat_clear", {chk_clr_a, check_a, busy_a, done_a}, 4'b1010);
      @(posedge clk); #1;
      check("lat_check", {chk_clr_a, check_a, commit_a}, 3'b010);
      check("stab_check", status_a, 8'hA5);
      @(posedge clk); #1;
      check("wait_pulses", {check_a, commit_a}, 2'b00);
      check("stab_wait", status_a, 8'hA5);
      @(posedge clk); #1;
      check("commit_pulse", commit_a, 1);
      check("stab_commit", status_a, 8'hA5);
      @(posedge clk); #1;
      check("step_hold", {commit_a, step_cnt_a}, 9'h000);
      @(posedge clk); #1;
      check("step_adv", {check_a, step_cnt_a}, 9'h101);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("repeat_done", {done_a, cycle_a, busy_a, timeout_a}, 4'b1100);

      // Table vectors, each started from DONE of the previous run.
      for (int i = 0; i < 5; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         run_a(vecs[i].rule, vecs[i].seed, tag);
         check({tag, "_cycle"}, cycle_a, vecs[i].cyc);
         check({tag, "_timeout"}, timeout_a, vecs[i].tmo);
         check({tag, "_step_cnt"}, step_cnt_a, vecs[i].steps);
         check({tag, "_status"}, status_a, vecs[i].fin);
         check({tag, "_n_clr"}, n_clr, 1);
         check({tag, "_n_check"}, n_chk, vecs[i].n_chk);
         check({tag, "_n_commit"}, n_com, vecs[i].n_com);
         check({tag, "_busy"}, busy_a, 0);
      end

      // Randomized rules and seeds against the reference model.
      for (int k = 0; k < 24; k++) begin
         string tag;
         tag = $sformatf("rnd%0d", k);
         r = 8'($urandom);
         s = 8'($urandom);
         ref_run(r, s, 255, e_cyc, e_tmo, e_steps, e_fin);
         run_a(r, s, tag);
         check({tag, "_cycle"}, cycle_a, e_cyc);
         check({tag, "_timeout"}, timeout_a, e_tmo);
         check({tag, "_step_cnt"}, step_cnt_a, e_steps);
         check({tag, "_status"}, status_a, e_fin);
         check({tag, "_n_check"}, n_chk, e_steps + (e_cyc ? 1 : 0));
      end

      // Budget exhaustion with start re-asserted while busy.
      @(negedge clk);
      rule_b = 8'hAA; seed_b = 8'h01; start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      repeat (5) @(negedge clk);
      rule_b = 8'h00; seed_b = 8'hFF; start_b = 1'b1;
      repeat (3) @(negedge clk);
      start_b = 1'b0;
      n = 0;
      while (!done_b && n < 100) begin @(negedge clk); n++; end
      check("tmo_done_seen", done_b, 1);
      check("tmo_flags", {timeout_b, cycle_b, busy_b}, 3'b100);
      check("tmo_step_cnt", step_cnt_b, 4);
      check("tmo_status", status_b, 8'h10);

      // Reset asserted during WAIT, then a normal run.
      @(negedge clk);
      rule_a = 8'hAA; seed_a = 8'h01; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      n = 0;
      while (!check_a && n < 20) begin @(negedge clk); n++; end
      check("mid_check_seen", check_a, 1);
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      check("mid_rst_status", status_a, 0);
      check("mid_rst_step_cnt", step_cnt_a, 0);
      check("mid_rst_flags", {chk_clr_a, check_a, commit_a, busy_a, done_a, cycle_a, timeout_a}, 0);
      @(negedge clk);
      reset = 1'b1;
      run_a(8'hCC, 8'h3C, "post_rst");
      check("post_rst_cycle", {cycle_a, timeout_a}, 2'b10);
      check("post_rst_step_cnt", step_cnt_a, 1);
      check("post_rst_status", status_a, 8'h3C);
      check("post_rst_n_clr", n_clr, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ca_stepper.md
# ca_stepper

Drives the 8-cell elementary cellular automaton whose successive generations feed `cycle_checker`, one stage upstream of it. It loads a seed and a rule, and clears the checker. For each generation it sequences the checker's compare pulse, waits for the verdict, then commits the generation to the checker's history before advancing. It halts when the checker reports a repeat or when a step budget expires.

## Interface
- `MAX_STEPS`, default 255: generation budget, range 1..255. At most 256 generations are ever committed, which keeps within the checker's 256-entry history.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low; low forces the reset state immediately.
- `start` in 1: level, sampled only in IDLE and DONE.
- `seed` in [0:7]: initial generation, latched on accepted `start`.
- `rule` in [7:0]: Wolfram rule number, latched on accepted `start`.
- `cycle_found` in 1: checker `result`, sampled in WAIT.
- `status` out [0:7]: current generation, to checker `status`.
- `chk_clr` out 1: one-cycle active-high pulse, to checker `reset`.
- `check` out 1: one-cycle pulse, to checker `clk`.
- `commit` out 1: one-cycle pulse, to checker `n_clk`.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: high in DONE.
- `cycle` out 1: run ended on a detected repeat.
- `timeout` out 1: run ended on budget exhaustion.
- `step_cnt` out 8: generations advanced in the current run.

## Operation
- States: IDLE, CLEAR, CHECK, WAIT, COMMIT, STEP, DONE.
- All outputs are decoded from registers only; there is no combinational input-to-output path.
- IDLE or DONE with `start`=1:
  - latch `seed` into `status` and `rule`;
  - clear `step_cnt`, `cycle` and `timeout`;
  - go to CLEAR.
- CLEAR: `chk_clr`=1, then go to CHECK.
- CHECK: `check`=1, then go to WAIT.
- WAIT:
  - `cycle_found`=1: set `cycle`, go to DONE;
  - otherwise go to COMMIT.
- COMMIT: `commit`=1, then go to STEP.
- STEP:
  - `status` ← next generation; `step_cnt` += 1;
  - if the new count equals `MAX_STEPS`, set `timeout` and go to DONE;
  - otherwise go to CHECK.
- DONE: `status`, `step_cnt`, `cycle` and `timeout` hold until the next accepted `start`.
- Next-generation rule:
  - cell `i`, index 0 leftmost, becomes `rule[{L,C,R}]`;
  - L = `status[i-1]`, C = `status[i]`, R = `status[i+1]`.
  - Edge neighbours are set by the Configuration section.
- `start` is ignored while `busy`=1.
- `cycle` and `timeout` are never both set.

## Timing
- Reset values:
  - state IDLE;
  - `status`=8'h00, `step_cnt`=0;
  - `chk_clr`, `check`, `commit`, `busy`, `done`, `cycle`, `timeout` all 0.
- Reset asserted mid-run: all outputs return to reset values immediately, with no pulse truncation side effects.
- Start latency:
  - `start` sampled at edge k;
  - `chk_clr` high for cycle k+1;
  - first `check` high for cycle k+2.
- Each generation takes 4 cycles: CHECK, WAIT, COMMIT, STEP.
- `cycle_found` must be valid one cycle after the `check` pulse; it is sampled at the end of WAIT.
- `status` is stable from CHECK through COMMIT and changes only on leaving STEP.
- `done` rises on the edge that leaves WAIT (repeat) or STEP (timeout).
- Starting from DONE behaves identically to starting from IDLE.

## Configuration
- `CA_WRAP_EN` defined: toroidal ring.
  - cell 0's L is `status[7]`;
  - cell 7's R is `status[0]`.
- `CA_WRAP_EN` undefined: out-of-range neighbours read as 0.

## Test plan
- Rule 8'h00, seed 8'hFF → generations FF, 00, 00; `cycle`=1, `step_cnt`=2, `chk_clr` pulsed exactly once.
- Rule 8'hCC (identity), seed 8'hA5 → repeat at generation 1; `cycle`=1, `step_cnt`=1; `commit` pulsed once and `check` twice.
- Rule 8'hAA, seed 8'h01, `CA_WRAP_EN` defined → 01, 02, 04 … 80, 01; `cycle`=1, `step_cnt`=8.
- Same stimulus with `CA_WRAP_EN` undefined → 01 … 80, 00, 00; `cycle`=1, `step_cnt`=9.
- `MAX_STEPS`=4, `cycle_found` tied 0 → `done`=1, `timeout`=1, `cycle`=0, `step_cnt`=4; `start` pulsed while `busy` has no effect.
- `reset` driven low during WAIT → all outputs at reset values within the same cycle; a new `start` then runs normally.
